// File: rtl/cv32e40p_pkg.sv
// Shared types for the sleep sequencer: FSM state encoding and default counter width.
package cv32e40p_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_IDLE  = 3'd3,
    S_SLEEP = 3'd4,
    S_WAKE  = 3'd5
  } sleep_state_e;

  localparam int unsigned SLEEP_CNT_W = 32;

endpackage

// File: rtl/cv32e40p_sleep_sequencer.sv
// Sequences clock-gated sleep entry/exit: drain, idle hysteresis, wake settle,
// plus a saturating gated-cycle counter for power profiling.
module cv32e40p_sleep_sequencer
  import cv32e40p_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 2,
  parameter int unsigned WAKE_CYCLES = 1,
  parameter int unsigned CNT_WIDTH   = SLEEP_CNT_W
) (
  input  logic                 clk_ungated_i,
  input  logic                 rst_n,
  input  logic                 fetch_enable_i,
  input  logic                 wfi_req_i,
  input  logic                 debug_req_i,
  input  logic                 wake_i,
  input  logic                 core_busy_i,
  input  logic                 sleep_cnt_clr_i,
  output logic                 fetch_enable_o,
  output logic                 clock_en_o,
  output logic                 core_sleep_o,
  output logic                 wfi_done_o,
  output logic [CNT_WIDTH-1:0] sleep_cnt_o
);

  localparam logic [3:0] IDLE_INIT = 4'(IDLE_CYCLES - 1);
  localparam logic [3:0] WAKE_INIT = 4'(WAKE_CYCLES);

  sleep_state_e         state_q, state_d;
  logic [3:0]           idle_cnt_q, idle_cnt_d;
  logic [3:0]           wake_cnt_q, wake_cnt_d;
  logic                 fetch_enable_q;
  logic                 wfi_done_q, wfi_done_d;
  logic [CNT_WIDTH-1:0] sleep_cnt_q;
  logic                 abort;

  assign abort = wake_i | debug_req_i;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    wfi_done_d = 1'b0;
    case (state_q)
      S_OFF: begin
        if (fetch_enable_q) state_d = S_RUN;
      end
      S_RUN: begin
        if (wfi_req_i && !debug_req_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort) begin
          state_d    = S_RUN;
          wfi_done_d = 1'b1;
        end else if (!core_busy_i) begin
          state_d    = S_IDLE;
          idle_cnt_d = IDLE_INIT;
        end
      end
      S_IDLE: begin
        // Abort beats busy beats gating, so a late wake never costs a sleep cycle.
        if (abort) begin
          state_d    = S_RUN;
          wfi_done_d = 1'b1;
        end else if (core_busy_i) begin
          state_d = S_DRAIN;
        end else if (idle_cnt_q == 4'd0) begin
          state_d = S_SLEEP;
        end else begin
          idle_cnt_d = idle_cnt_q - 4'd1;
        end
      end
      S_SLEEP: begin
        if (abort) begin
          if (WAKE_CYCLES == 0) begin
            state_d    = S_RUN;
            wfi_done_d = 1'b1;
          end else begin
            state_d    = S_WAKE;
            wake_cnt_d = WAKE_INIT;
          end
        end
      end
      S_WAKE: begin
        if (wake_cnt_q <= 4'd1) begin
          state_d    = S_RUN;
          wfi_done_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_OFF;
      idle_cnt_q     <= 4'd0;
      wake_cnt_q     <= 4'd0;
      fetch_enable_q <= 1'b0;
      wfi_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      wake_cnt_q     <= wake_cnt_d;
      fetch_enable_q <= fetch_enable_q | fetch_enable_i;
      wfi_done_q     <= wfi_done_d;
    end
  end

  // Wake/debug open the gate combinationally so the core clocks in the event cycle.
  assign clock_en_o     = fetch_enable_q &&
                          (((state_q != S_OFF) && (state_q != S_SLEEP)) || abort);
  assign core_sleep_o   = (state_q == S_SLEEP) && !clock_en_o;
  assign fetch_enable_o = fetch_enable_q;
  assign wfi_done_o     = wfi_done_q;

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      sleep_cnt_q <= '0;
    end else if (sleep_cnt_clr_i) begin
      sleep_cnt_q <= '0;
    end else if (core_sleep_o && !(&sleep_cnt_q)) begin
      sleep_cnt_q <= sleep_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign sleep_cnt_o = sleep_cnt_q;

  // The controller must hold its WFI request until the sequence retires.
  wfi_held_a: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
    (state_q inside {S_DRAIN, S_IDLE, S_SLEEP, S_WAKE}) |-> wfi_req_i);

endmodule

// File: tb/tb_cv32e40p_sleep_sequencer.sv
// Directed bench for the sleep sequencer with a cycle model checked every cycle.
module tb_cv32e40p_sleep_sequencer;

  localparam int IDLE_C = 2;
  localparam int WAKE_C = 1;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_enable_i, wfi_req_i, debug_req_i, wake_i, core_busy_i, sleep_cnt_clr_i;
  logic fetch_enable_o, clock_en_o, core_sleep_o, wfi_done_o;
  logic [CNT_W-1:0] sleep_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cv32e40p_sleep_sequencer #(
    .IDLE_CYCLES(IDLE_C),
    .WAKE_CYCLES(WAKE_C),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk_ungated_i  (clk),
    .rst_n          (rst_n),
    .fetch_enable_i (fetch_enable_i),
    .wfi_req_i      (wfi_req_i),
    .debug_req_i    (debug_req_i),
    .wake_i         (wake_i),
    .core_busy_i    (core_busy_i),
    .sleep_cnt_clr_i(sleep_cnt_clr_i),
    .fetch_enable_o (fetch_enable_o),
    .clock_en_o     (clock_en_o),
    .core_sleep_o   (core_sleep_o),
    .wfi_done_o     (wfi_done_o),
    .sleep_cnt_o    (sleep_cnt_o)
  );

  // Model modes: 0 off, 1 running, 2 WFI pending (waiting for quiet cycles),
  // 3 asleep, 4 settling after wake. m_seen counts consecutive quiet cycles.
  int m_mode   = 0;
  int m_seen   = 0;
  int m_settle = 0;
  int m_cnt    = 0;
  bit m_fe     = 1'b0;
  bit m_done   = 1'b0;

  function automatic bit exp_ce();
    return m_fe && ((m_mode != 0 && m_mode != 3) || wake_i || debug_req_i);
  endfunction

  function automatic bit exp_sleep();
    return (m_mode == 3) && !exp_ce();
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit ev;
    bit done;
    int nmode;
    if (!rst_n) begin
      m_mode = 0; m_seen = 0; m_settle = 0; m_cnt = 0; m_fe = 1'b0; m_done = 1'b0;
    end else begin
      ev    = wake_i || debug_req_i;
      done  = 1'b0;
      nmode = m_mode;
      if (sleep_cnt_clr_i) m_cnt = 0;
      else if (exp_sleep() && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (m_mode == 0) begin
        if (m_fe) nmode = 1;
      end else if (m_mode == 1) begin
        if (wfi_req_i && !debug_req_i) begin nmode = 2; m_seen = 0; end
      end else if (m_mode == 2) begin
        if (ev) begin nmode = 1; done = 1'b1; end
        else if (core_busy_i) m_seen = 0;
        else if (m_seen == IDLE_C) nmode = 3;
        else m_seen = m_seen + 1;
      end else if (m_mode == 3) begin
        if (ev) begin
          if (WAKE_C == 0) begin nmode = 1; done = 1'b1; end
          else begin nmode = 4; m_settle = WAKE_C; end
        end
      end else begin
        if (m_settle <= 1) begin nmode = 1; done = 1'b1; end
        else m_settle = m_settle - 1;
      end
      m_fe   = m_fe | fetch_enable_i;
      m_done = done;
      m_mode = nmode;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_fetch_enable", 32'(fetch_enable_o), 32'(m_fe));
    chk("m_clock_en",     32'(clock_en_o),     32'(exp_ce()));
    chk("m_core_sleep",   32'(core_sleep_o),   32'(exp_sleep()));
    chk("m_wfi_done",     32'(wfi_done_o),     32'(m_done));
    chk("m_sleep_cnt",    32'(sleep_cnt_o),    32'(m_cnt));
  endtask

  // Check the current cycle against the model, then move to the next negedge.
  task automatic cyc();
    #1;
    model_check();
    @(negedge clk);
    if (m_done) wfi_req_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_enable_i = 1'b0; wfi_req_i = 1'b0; debug_req_i = 1'b0;
    wake_i = 1'b0; core_busy_i = 1'b0; sleep_cnt_clr_i = 1'b0;
    @(negedge clk);
    cyc(); cyc();
    #1;
    chk("reset_clock_en", 32'(clock_en_o), 0);
    chk("reset_sleep_cnt", 32'(sleep_cnt_o), 0);
    rst_n = 1'b1;
    cyc();

    // Fetch enable pulse: sticky next cycle, RUN the cycle after
    fetch_enable_i = 1'b1; cyc(); fetch_enable_i = 1'b0;
    #1;
    chk("fe_sticky", 32'(fetch_enable_o), 1);
    chk("fe_off_gate", 32'(clock_en_o), 0);
    cyc();
    #1; chk("run_gate_open", 32'(clock_en_o), 1);
    cyc();

    // WFI with idle core: asleep on the 4th cycle after request
    wfi_req_i = 1'b1; cyc();
    cyc(); cyc();
    #1; chk("idle2_not_asleep", 32'(core_sleep_o), 0);
    cyc();
    #1;
    chk("sleep_gate_closed", 32'(clock_en_o), 0);
    chk("sleep_asserted", 32'(core_sleep_o), 1);
    repeat (10) cyc();
    wake_i = 1'b1;
    #1;
    chk("wake_gate_same_cycle", 32'(clock_en_o), 1);
    chk("wake_not_asleep", 32'(core_sleep_o), 0);
    chk("sleep_cnt_10", 32'(sleep_cnt_o), 10);
    cyc();
    wake_i = 1'b0;
    #1;
    chk("settle_gate_open", 32'(clock_en_o), 1);
    chk("settle_no_done", 32'(wfi_done_o), 0);
    cyc();
    #1;
    chk("wake_done_pulse", 32'(wfi_done_o), 1);
    chk("sleep_cnt_hold", 32'(sleep_cnt_o), 10);
    cyc();
    #1; chk("done_one_cycle", 32'(wfi_done_o), 0);
    cyc();

    // Busy holds DRAIN; busy in IDLE restarts hysteresis
    core_busy_i = 1'b1; wfi_req_i = 1'b1; cyc();
    repeat (4) cyc();
    #1;
    chk("drain_busy_gate", 32'(clock_en_o), 1);
    chk("drain_busy_awake", 32'(core_sleep_o), 0);
    core_busy_i = 1'b0; cyc();
    core_busy_i = 1'b1; cyc();
    core_busy_i = 1'b0; cyc(); cyc();
    #1; chk("hyst_restart_awake", 32'(core_sleep_o), 0);
    cyc();
    #1; chk("hyst_then_sleep", 32'(core_sleep_o), 1);
    repeat (20) cyc();
    #1; chk("sleep_cnt_saturate", 32'(sleep_cnt_o), 15);
    sleep_cnt_clr_i = 1'b1; cyc(); sleep_cnt_clr_i = 1'b0;
    #1; chk("sleep_cnt_clear", 32'(sleep_cnt_o), 0);
    cyc();
    debug_req_i = 1'b1;
    #1;
    chk("cnt_after_clear", 32'(sleep_cnt_o), 1);
    chk("debug_gate_open", 32'(clock_en_o), 1);
    cyc();
    debug_req_i = 1'b0; cyc();
    #1; chk("debug_wake_done", 32'(wfi_done_o), 1);
    cyc();

    // Debug during IDLE aborts the WFI
    wfi_req_i = 1'b1; cyc(); cyc();
    debug_req_i = 1'b1;
    #1; chk("dbg_idle_awake", 32'(core_sleep_o), 0);
    cyc();
    debug_req_i = 1'b0;
    #1; chk("dbg_idle_done", 32'(wfi_done_o), 1);
    cyc();

    // WFI together with debug in RUN: no sequence starts
    wfi_req_i = 1'b1; debug_req_i = 1'b1;
    cyc(); cyc(); cyc();
    #1;
    chk("wfi_dbg_gate", 32'(clock_en_o), 1);
    chk("wfi_dbg_no_done", 32'(wfi_done_o), 0);
    wfi_req_i = 1'b0; debug_req_i = 1'b0;
    cyc();

    // Wake in the very cycle IDLE would gate
    wfi_req_i = 1'b1; cyc(); cyc(); cyc();
    wake_i = 1'b1;
    #1; chk("late_wake_gate", 32'(clock_en_o), 1);
    cyc();
    wake_i = 1'b0;
    #1;
    chk("late_wake_done", 32'(wfi_done_o), 1);
    chk("late_wake_no_sleep", 32'(core_sleep_o), 0);
    cyc();

    // Reset while asleep
    wfi_req_i = 1'b1; repeat (4) cyc();
    #1; chk("pre_reset_asleep", 32'(core_sleep_o), 1);
    #2; rst_n = 1'b0;
    #1;
    chk("arst_fetch_enable", 32'(fetch_enable_o), 0);
    chk("arst_clock_en", 32'(clock_en_o), 0);
    chk("arst_core_sleep", 32'(core_sleep_o), 0);
    chk("arst_wfi_done", 32'(wfi_done_o), 0);
    chk("arst_sleep_cnt", 32'(sleep_cnt_o), 0);
    wfi_req_i = 1'b0;
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    #1;
    chk("post_reset_gate", 32'(clock_en_o), 0);
    chk("post_reset_fe", 32'(fetch_enable_o), 0);
    cyc();
    fetch_enable_i = 1'b1; cyc(); fetch_enable_i = 1'b0; cyc();
    #1; chk("refetch_gate", 32'(clock_en_o), 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_sleep_sequencer.md
Name: cv32e40p_sleep_sequencer

Overview:
Sequences the core's entry into and exit from clock-gated sleep. Drives the enable of the main clock gate from a small FSM that drains busy units, applies idle hysteresis, honours wake/debug aborts and inserts a wake settle window. Sits beside the controller: the controller raises wfi_req_i; the sequencer drives clock_en_o to the core clock gate and core_sleep_o to the SoC. Also keeps a saturating count of gated cycles for power-profiling CSRs.

Parameters:
IDLE_CYCLES, 2, consecutive non-busy cycles required before gating (legal 1..15)
WAKE_CYCLES, 1, ungated settle cycles after wake before WFI retires (legal 0..15)
CNT_WIDTH, 32, width of sleep cycle counter

Ports:
clk_ungated_i  in  1  free-running clock
rst_n  in  1  reset
fetch_enable_i  in  1  SoC fetch enable; sampled sticky
wfi_req_i  in  1  controller WFI request, level, held until wfi_done_o
debug_req_i  in  1  pending debug/single-step/trigger; forbids sleep
wake_i  in  1  wake event (pending enabled irq)
core_busy_i  in  1  OR of IF/ctrl/LSU/APU busy
sleep_cnt_clr_i  in  1  synchronous clear of sleep counter
fetch_enable_o  out  1  sticky fetch enable to controller
clock_en_o  out  1  enable to core clock gate
core_sleep_o  out  1  core asleep indication
wfi_done_o  out  1  one-cycle pulse: WFI retired, core back in RUN
sleep_cnt_o  out  CNT_WIDTH  saturating count of gated cycles

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk_ungated_i. State S_OFF, counters 0; fetch_enable_o=0, clock_en_o=0, core_sleep_o=0, wfi_done_o=0, sleep_cnt_o=0.
- fetch_enable_q sets on fetch_enable_i, never clears until reset; fetch_enable_o = fetch_enable_q.
- States: S_OFF, S_RUN, S_DRAIN, S_IDLE, S_SLEEP, S_WAKE. All transitions registered.
- S_OFF: fetch_enable_q=1 -> S_RUN.
- S_RUN: wfi_req_i && !debug_req_i -> S_DRAIN.
- S_DRAIN: wake_i || debug_req_i -> S_RUN, pulse wfi_done_o; else !core_busy_i -> S_IDLE, idle_cnt <= IDLE_CYCLES-1.
- S_IDLE: priority wake_i||debug_req_i -> S_RUN (pulse wfi_done_o); core_busy_i -> S_DRAIN; idle_cnt==0 -> S_SLEEP; else idle_cnt decrements.
- S_SLEEP: wake_i || debug_req_i -> S_WAKE with wake_cnt <= WAKE_CYCLES, or direct to S_RUN with wfi_done_o pulse if WAKE_CYCLES==0.
- S_WAKE: wake_cnt==1 -> S_RUN, pulse wfi_done_o; else decrement. Wake/debug deasserting here does not re-enter sleep.
- clock_en_o (combinational) = fetch_enable_q && ((state!=S_OFF && state!=S_SLEEP) || wake_i || debug_req_i). The wake path is combinational so the gate opens in the same cycle as the event.
- core_sleep_o = (state==S_SLEEP) && !clock_en_o.
- wfi_done_o asserts exactly in the first S_RUN cycle after leaving DRAIN/IDLE/WAKE/SLEEP (registered pulse, 1 cycle).
- sleep_cnt: +1 each cycle core_sleep_o=1; saturates at all-ones; sleep_cnt_clr_i has priority over increment.
- Simultaneous: wfi_req_i with debug_req_i in S_RUN -> stay S_RUN. wake_i in the same cycle S_IDLE would gate -> S_RUN, no sleep cycle.
- wfi_req_i deasserting mid-sequence is a protocol violation (assertion); the FSM ignores it.
- Reset mid-sleep: immediate return to S_OFF, clock_en_o=0; fetch must be re-enabled.

Decomposition:
- cv32e40p_pkg: sleep_state_e enum (3-bit, S_OFF=0), SLEEP_CNT_W default constant.
- No sub-module. The parent instantiates cv32e40p_clock_gate, fed by clock_en_o.

Test Plan:
- Reset, fetch_enable_i pulse 1 cycle at t0 -> fetch_enable_o=1 at t0+1; S_RUN at t0+2; clock_en_o=1 held.
- wfi_req_i=1, busy=0 (IDLE_CYCLES=2) -> clock_en_o=0 and core_sleep_o=1 on cycle 4 after request (DRAIN, IDLE, IDLE, SLEEP).
- In sleep 10 cycles, wake_i=1 -> clock_en_o=1 same cycle; wfi_done_o pulses 2 cycles later (WAKE_CYCLES=1); sleep_cnt_o=10.
- wfi_req_i with core_busy_i=1 for 5 cycles -> stays S_DRAIN, clock_en_o=1; busy toggling in S_IDLE returns to S_DRAIN and restarts hysteresis.
- debug_req_i=1 during S_IDLE -> S_RUN, wfi_done_o pulse, core_sleep_o never asserted; wfi_req_i+debug_req_i in S_RUN -> no transition.
- CNT_WIDTH=4, sleep 20 cycles -> sleep_cnt_o=15 (saturated); sleep_cnt_clr_i with active sleep -> 0 next cycle; rst_n low in S_SLEEP -> all outputs 0 asynchronously.
